sseg_scan_ctrl_amisha: RTL

//  Parametrised N-digit seven-segment scan controller with brightness control. Replaces the fixed 4-digit mux.
//  - Latches hex nibbles, decimal points and blank masks through a tear-free shadow register.
//  - Applies leading-zero suppression, then time-multiplexes the digits onto one anode/segment bus.
//  - Adds PWM dimming and anode dead-time between digit slots.
//  - Sits between board-level test/readout logic and the display pins.

---
 rtl/sseg_scan_ctrl_amisha_pkg.sv | 21 ++
 rtl/sseg_scan_ctrl_amisha_timer.sv | 51 +++++
 rtl/sseg_scan_ctrl_amisha.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sseg_scan_ctrl_amisha_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package sseg_pkg_amisha;

  // Hex glyphs, active-high, bit order g,f,e,d,c,b,a. Index 15 is listed first.
  // Letters b and d use their lowercase forms.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Convert an active-high pin pattern to the board's pin polarity.
  function automatic logic [7:0] apply_pol(input logic [7:0] value, input bit active_low);
    return active_low ? ~value : value;
  endfunction

  // Width of a digit index; never narrower than one bit.
  function automatic int idx_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/sseg_scan_ctrl_amisha_timer.sv
// Slot timer: slot counter, scanned digit index, free-running PWM counter,
// dead-time flag and the one-cycle pulse that marks the scan returning to digit 0.
module sseg_slot_timer_amisha
  import sseg_pkg_amisha::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SLOT_CYCLES = 50000,
  parameter int DEAD_CYCLES = 16,
  parameter int PWM_BITS    = 4,
  localparam int IDX_W      = idx_width(NUM_DIGITS),
  localparam int CNT_W      = $clog2(SLOT_CYCLES)
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [IDX_W-1:0]    digit_idx,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                dead,
  output logic                wrap,
  output logic                frame
);

  logic [CNT_W-1:0] slot_cnt;
  logic             slot_last;
  logic             idx_last;

  assign slot_last = (slot_cnt == CNT_W'(SLOT_CYCLES - 1));
  assign idx_last  = (digit_idx == IDX_W'(NUM_DIGITS - 1));
  // The clock edge that ends the last digit's slot moves the scan back to digit 0.
  assign wrap      = slot_last && idx_last;
  assign dead      = (slot_cnt < CNT_W'(DEAD_CYCLES));

  // Advance slot/PWM counters, step the digit at slot end, flag the frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
      pwm_cnt   <= '0;
      frame     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      frame   <= wrap;
      if (slot_last) begin
        slot_cnt  <= '0;
        digit_idx <= idx_last ? '0 : digit_idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl_amisha.sv
// N-digit seven-segment scan controller: tear-free shadow load, leading-zero
// suppression, digit multiplexing with PWM dimming and anode dead time.
// Reset release is expected to be synchronised to clk_amisha upstream.
//
// load_amisha is a single-cycle strobe with no back-pressure: every cycle it is
// high, hex/dp/blank/lz_en are captured into the pending register (last wins).
// Pending is copied to the active register only at the edge that wraps the scan
// to digit 0, so a displayed frame never mixes two loads.
module sseg_scan_ctrl_amisha
  import sseg_pkg_amisha::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SLOT_CYCLES = 50000,
  parameter int DEAD_CYCLES = 16,
  parameter int PWM_BITS    = 4,
  parameter bit ACTIVE_LOW  = 1'b1,
  localparam int IDX_W      = idx_width(NUM_DIGITS)
) (
  input  logic                    clk_amisha,
  input  logic                    reset_amisha,
  input  logic [4*NUM_DIGITS-1:0] hex_amisha,
  input  logic [NUM_DIGITS-1:0]   dp_amisha,
  input  logic [NUM_DIGITS-1:0]   blank_amisha,
  input  logic                    lz_en_amisha,
  input  logic [PWM_BITS-1:0]     bright_amisha,
  input  logic                    load_amisha,
  output logic [NUM_DIGITS-1:0]   an_amisha,
  output logic [7:0]              sseg_amisha,
  output logic [IDX_W-1:0]        digit_idx_amisha,
  output logic                    frame_amisha
);

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [7:0]            SEG_OFF = {8{ACTIVE_LOW}};

  logic [IDX_W-1:0]    digit_idx;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                dead;
  logic                wrap;

  sseg_slot_timer_amisha #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SLOT_CYCLES (SLOT_CYCLES),
    .DEAD_CYCLES (DEAD_CYCLES),
    .PWM_BITS    (PWM_BITS)
  ) u_timer (
    .clk       (clk_amisha),
    .rst_n     (reset_amisha),
    .digit_idx (digit_idx),
    .pwm_cnt   (pwm_cnt),
    .dead      (dead),
    .wrap      (wrap),
    .frame     (frame_amisha)
  );

  assign digit_idx_amisha = digit_idx;

  logic [4*NUM_DIGITS-1:0] pend_hex, act_hex;
  logic [NUM_DIGITS-1:0]   pend_dp, act_dp;
  logic [NUM_DIGITS-1:0]   pend_blank, act_blank;
  logic                    pend_lz, act_lz;

  // Shadow registers: capture on load, promote to active at the scan wrap.
  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      pend_hex   <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_lz    <= 1'b0;
      act_hex    <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      act_lz     <= 1'b0;
    end else begin
      if (load_amisha) begin
        pend_hex   <= hex_amisha;
        pend_dp    <= dp_amisha;
        pend_blank <= blank_amisha;
        pend_lz    <= lz_en_amisha;
      end
      if (wrap) begin
        act_hex   <= pend_hex;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
        act_lz    <= pend_lz;
      end
    end
  end

  logic [NUM_DIGITS-1:0] dark;

  // Dark mask: blanked digits plus leading zeros scanning down from the top
  // digit; digit 0 is never suppressed so an all-zero value still shows "0".
  always_comb begin
    logic still_zero;
    still_zero = act_lz;
    dark       = act_blank;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      still_zero = still_zero && (act_hex[4*k +: 4] == 4'h0);
      if (still_zero) dark[k] = 1'b1;
    end
  end

  logic [3:0] cur_nib;
  logic       cur_dp;
  logic       cur_dark;

  // Select the nibble, decimal point and dark flag of the digit being scanned.
  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        cur_nib  = act_hex[4*k +: 4];
        cur_dp   = act_dp[k];
        cur_dark = dark[k];
      end
    end
  end

  logic                  pwm_on;
  logic                  anode_on;
  logic [NUM_DIGITS-1:0] an_raw;
  logic [7:0]            seg_raw;

  assign pwm_on   = (bright_amisha == '1) || (pwm_cnt < bright_amisha);
  assign anode_on = !dead && pwm_on && !cur_dark;

  // One-hot anode for the scanned digit (or none) and its active-high glyph.
  always_comb begin
    an_raw = '0;
    if (anode_on) an_raw[digit_idx] = 1'b1;
    seg_raw = cur_dark ? 8'h00 : {cur_dp, SEG_GLYPH[cur_nib]};
  end

  // Output registers in board polarity; a dark digit leaves both buses inactive.
  always_ff @(posedge clk_amisha or negedge reset_amisha) begin
    if (!reset_amisha) begin
      an_amisha   <= AN_OFF;
      sseg_amisha <= SEG_OFF;
    end else begin
      an_amisha   <= an_raw ^ AN_OFF;
      sseg_amisha <= apply_pol(seg_raw, ACTIVE_LOW);
    end
  end

endmodule
